irq_encoder8_3: RTL
===================

# irq_encoder8_3

Eight-source interrupt encoder for the MIDI interface: the inverse of the 3-to-8 select decoder. It synchronises eight asynchronous request lines, latches rising edges as pending events, and applies a write-enabled mask. It presents the highest-priority unmasked source to the host as a 3-bit vector with a level interrupt, and holds that vector until the host acknowledges it.

## Interface
- SYNC_STAGES, 2, number of synchroniser flops per request line (≥2).
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  8  asynchronous interrupt request lines; a rising edge is an event.
- mask_we  in  1  mask write strobe, one cycle.
- mask_din  in  8  new mask value; 1 = source enabled.
- ack  in  1  one-cycle acknowledge of the presented vector.
- irq  out  1  interrupt to host, active-high.
- vec  out  3  index of the presented source; valid while irq = 1.
- pending  out  8  raw pending register, for status reads.
- mask  out  8  current mask register.

## Operation
- Reset values:
  - irq = 0, vec = 3'd0, pending = 8'h00, mask = 8'h00 (all sources disabled).
  - All synchroniser and edge-detect flops = 0.
- Edge capture:
  - Each req bit passes through SYNC_STAGES flops, then one delay flop.
  - Event when the last sync stage = 1 and the delay flop = 0. This sets the pending bit.
  - A req line already high at reset release therefore counts as one event.
- Active set = pending & mask. Priority: bit 7 highest, bit 0 lowest.
- Masking does not clear pending. Unmasking a pending source makes it eligible on the next cycle.
- mask_we loads mask_din on the clock edge; mask reads back the new value the following cycle.
- FSM states:
  - IDLE: irq = 0. If the active set is non-zero, latch the priority-encoded index into vec and go to ASSERT.
  - ASSERT: irq = 1 and vec is frozen; there is no preemption by higher-priority sources. On ack, clear pending[vec], drive irq = 0, go to GAP.
  - GAP: irq = 0 for one cycle, then go to IDLE unconditionally.
- ack in IDLE or GAP is ignored and has no effect on pending.
- Simultaneous set and clear of the same pending bit (a new edge in the ack cycle): set wins and the bit stays 1.
- Masking the presented source while in ASSERT does not withdraw irq. The vector stays presented until ack.
- mask_we in the same cycle as an IDLE→ASSERT decision: the decision uses the old mask.

## Timing
- Request to pending: the req edge is first sampled at edge 0; pending is set at edge SYNC_STAGES+1.
- Pending to irq: irq rises at edge SYNC_STAGES+2. With the default, that is 4 cycles after first sampling.
- Ack to irq low: ack sampled at edge k makes irq = 0 from edge k. The pending bit is also cleared at edge k.
- Re-assertion: earliest at edge k+2, so irq is low for at least 2 cycles between vectors.
- vec changes only on the IDLE→ASSERT edge.
- Asynchronous reset mid-ASSERT: irq drops immediately and all pending events are lost.

## Structure
- Shared package `irq_enc_pkg`:
  - state enum (IDLE, ASSERT, GAP).
  - constants N_SRC = 8, VEC_W = 3.
  - reset constant MASK_RST = 8'h00.
- Sub-module `prio_enc8_3`: combinational, input 8-bit active set, outputs 3-bit index and any-bit flag. Bit 7 has priority.
- Synchroniser and edge detect live in the top module as a generate loop.

## Test plan
- Reset, mask_din = 8'hFF, pulse req[5]: irq = 1 and vec = 5 after 4 cycles; pending = 8'h20; ack → irq = 0 and pending = 8'h00.
- Mask 8'hFF, req[2] and req[6] rise together: vec = 6 first. After ack and the 2-cycle gap, vec = 2. After the second ack, pending = 0.
- Mask 8'h00, req[3] rises: pending = 8'h08 with irq = 0. Write mask 8'h08: irq = 1 and vec = 3 two cycles later.
- In ASSERT with vec = 1, req[7] rises: vec stays 1 until ack, then vec = 7.
- New req[4] edge lands on the ack cycle for vec = 4: pending[4] stays 1 and irq reasserts with vec = 4 at k+2.
- Assert reset mid-ASSERT: irq, vec and pending go to 0 immediately. req held high through reset release yields one event.

Source files
------------

// File: rtl/irq_enc_pkg.sv
// Shared types and constants for the eight-source interrupt encoder.
// Holds the controller state enum and the mask reset value.
package irq_enc_pkg;

  localparam int N_SRC = 8;
  localparam int VEC_W = 3;

  localparam logic [N_SRC-1:0] MASK_RST = 8'h00;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_e;

endpackage

// File: rtl/irq_encoder8_3_prio.sv
// Combinational 8-to-3 priority encoder.
// Bit 7 has the highest priority.
module prio_enc8_3
  import irq_enc_pkg::*;
(
  input  logic [N_SRC-1:0] act,
  output logic [VEC_W-1:0] idx,
  output logic             any
);

  // Scan upward so the highest set bit is the last one written
  always_comb begin
    idx = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (act[i]) idx = VEC_W'(i);
    end
  end

  assign any = |act;

endmodule

// File: rtl/irq_encoder8_3.sv
// Eight-source interrupt encoder: sync, edge capture, mask,
// priority select and an ack handshake toward the host.
module irq_encoder8_3
  import irq_enc_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] req,
  input  logic             mask_we,
  input  logic [N_SRC-1:0] mask_din,
  input  logic             ack,
  output logic             irq,
  output logic [VEC_W-1:0] vec,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  logic [N_SRC-1:0] evt;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   dly_q, dly_d;
    logic                   edge_q, edge_d;

    // Shift the request through the chain and flag a rising edge
    always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], req[g]};
      dly_d  = sync_q[SYNC_STAGES-1];
      edge_d = sync_q[SYNC_STAGES-1] & ~dly_q;
    end

    // Synchroniser, delay and edge flops
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
        dly_q  <= 1'b0;
        edge_q <= 1'b0;
      end else begin
        sync_q <= sync_d;
        dly_q  <= dly_d;
        edge_q <= edge_d;
      end
    end

    assign evt[g] = edge_q;
  end

  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] active;
  logic [N_SRC-1:0] clr;
  logic [VEC_W-1:0] top_idx;
  logic             top_any;

  assign active = pend_q & mask_q;

  prio_enc8_3 u_prio (
    .act (active),
    .idx (top_idx),
    .any (top_any)
  );

  // Next state, latched vector and the ack-driven clear
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    clr     = '0;
    irq     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (top_any) begin
          state_d = ASSERT;
          vec_d   = top_idx;
        end
      end
      ASSERT: begin
        irq = 1'b1;
        if (ack) begin
          clr[vec_q] = 1'b1;
          state_d    = GAP;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pending bits: a new edge wins over a same-cycle clear
  always_comb begin
    pend_d = (pend_q & ~clr) | evt;
    mask_d = mask_we ? mask_din : mask_q;
  end

  // Controller, pending and mask registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      vec_q   <= '0;
      pend_q  <= '0;
      mask_q  <= MASK_RST;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
    end
  end

  assign vec     = vec_q;
  assign pending = pend_q;
  assign mask    = mask_q;

endmodule
